// File: rtl/video_slot_arbiter_if.sv
// rtl/video_slot_arbiter_if.sv - fetcher/RAM-side signal bundle of the video slot arbiter
interface video_slot_arbiter_if #(
  parameter int AW = 23
);
  logic          clk_8_en;
  logic [1:0]    bus_cycle;
  logic          viking_en;
  logic          viking_only;
  logic          req0;
  logic [AW-1:0] addr0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [AW-1:0] ram_addr;
  logic          ram_read;
  logic [63:0]   ram_data;
  logic          ack0;
  logic          ack1;
  logic [63:0]   dout;
  logic          grant_owner;

  modport slave (
    input  clk_8_en, bus_cycle, viking_en, viking_only,
    input  req0, addr0, req1, addr1, ram_data,
    output ram_addr, ram_read, ack0, ack1, dout, grant_owner
  );

  modport master (
    output clk_8_en, bus_cycle, viking_en, viking_only,
    output req0, addr0, req1, addr1, ram_data,
    input  ram_addr, ram_read, ack0, ack1, dout, grant_owner
  );
endinterface

// File: rtl/video_slot_arbiter.sv
// rtl/video_slot_arbiter.sv - shares the bus_cycle 3 video read slot between Viking and shifter fetchers
module video_slot_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 23
) (
  input  logic                  clk,
  input  logic                  reset_n,
  video_slot_arbiter_if.slave   bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_READ, S_RETURN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_wait0;
  logic [WW-1:0] r_wait1;
  logic [WW-1:0] w_wait0_nxt;
  logic [WW-1:0] w_wait1_nxt;
  logic          r_owner;
  logic [AW-1:0] r_ram_addr;
  logic [63:0]   r_dout;
  logic          w_e0;
  logic          w_e1;
  logic          w_win;
  logic          w_sample;
  logic          w_capture;
  logic          w_read;
  logic          w_ack0;
  logic          w_ack1;

  assign w_e0     = bus.req0 & bus.viking_en;
  assign w_e1     = bus.req1 & ~bus.viking_only;
  assign w_sample = (r_state == S_ARB) & bus.clk_8_en & (bus.bus_cycle == 2'd2);

  // Viking wins ties unless the shifter has aged out; two aged requesters alternate.
  always_comb begin
    w_win = 1'b0;
    if (w_e1 && !w_e0) begin
      w_win = 1'b1;
    end else if (w_e0 && w_e1) begin
      if (r_wait0 == W_MAX && r_wait1 == W_MAX) w_win = ~r_owner;
      else if (r_wait1 == W_MAX)                 w_win = 1'b1;
    end
  end

  always_comb begin
    w_wait0_nxt = '0;
    w_wait1_nxt = '0;
    if (w_e0 && w_win)
      w_wait0_nxt = (r_wait0 == W_MAX) ? W_MAX : r_wait0 + WW'(1);
    if (w_e1 && !w_win)
      w_wait1_nxt = (r_wait1 == W_MAX) ? W_MAX : r_wait1 + WW'(1);
  end

  always_comb begin
    w_next    = r_state;
    w_read    = 1'b0;
    w_ack0    = 1'b0;
    w_ack1    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clk_8_en && bus.bus_cycle == 2'd1) w_next = S_ARB;
      end
      S_ARB: begin
        if (bus.clk_8_en)
          w_next = (bus.bus_cycle == 2'd2 && (w_e0 || w_e1)) ? S_READ : S_IDLE;
      end
      S_READ: begin
        w_read = 1'b1;
        if (bus.clk_8_en) begin
          if (bus.bus_cycle == 2'd3) begin
            w_next    = S_RETURN;
            w_capture = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_RETURN: begin
        w_ack0 = ~r_owner;
        w_ack1 = r_owner;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wait0    <= '0;
      r_wait1    <= '0;
      r_owner    <= 1'b0;
      r_ram_addr <= '0;
      r_dout     <= '0;
    end else begin
      r_state <= w_next;
      if (w_sample) begin
        r_wait0 <= w_wait0_nxt;
        r_wait1 <= w_wait1_nxt;
        if (w_e0 || w_e1) begin
          r_owner    <= w_win;
          r_ram_addr <= w_win ? bus.addr1 : bus.addr0;
        end
      end
      if (w_capture) r_dout <= bus.ram_data;
    end
  end

  assign bus.ram_read    = w_read;
  assign bus.ack0        = w_ack0;
  assign bus.ack1        = w_ack1;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.dout        = r_dout;
  assign bus.grant_owner = r_owner;
endmodule
